video_timing: RTL and testbench

VIDEO_TIMING -- requirements
Module: VIDEO_timing

---
 rtl/video_timing.sv | 158 +++++++++++++++
 tb/tb_video_timing.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// Raster timing generator with pixel/line counters, sync/blank flags, a line-compare
// interrupt and a small CPU register file behind an IDLE/ACK/HOLD handshake.
module video_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_pixel_enable,
    input  logic        i_cpu_request,
    input  logic        i_cpu_rw,
    input  logic [31:0] i_cpu_address,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_ready,
    output logic        o_hblank,
    output logic        o_vblank,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_data_enable,
    output logic [10:0] o_pos_x,
    output logic [10:0] o_pos_y,
    output logic        o_line_irq
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SS   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SE   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SS   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SE   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [10:0] h, v, h_n, v_n, line_cmp;
    logic [31:0] frame, reg_rd;
    logic [1:0]  state;
    logic        ctrl_en, irq_en;
    logic        accept, wr_ctrl, wr_cmp, en_next, step, h_wrap, v_wrap;

    assign accept  = (state == ST_IDLE) && i_cpu_request;
    assign wr_ctrl = accept && i_cpu_rw && (i_cpu_address[3:2] == 2'd0);
    assign wr_cmp  = accept && i_cpu_rw && (i_cpu_address[3:2] == 2'd1);

    // A CONTROL write acts on the same edge it is accepted, so disable and
    // restart line up with the write rather than lagging a cycle.
    assign en_next = wr_ctrl ? i_cpu_wdata[0] : ctrl_en;
    assign step    = i_pixel_enable && ctrl_en && en_next;
    assign h_wrap  = (h == H_LAST);
    assign v_wrap  = (v == V_LAST);

    always_comb begin
        h_n = h;
        v_n = v;
        if (step) begin
            h_n = h_wrap ? '0 : h + 11'd1;
            if (h_wrap) begin
                v_n = v_wrap ? '0 : v + 11'd1;
            end
        end
    end

    always_comb begin
        reg_rd = '0;
        case (i_cpu_address[3:2])
            2'd0:    reg_rd = {30'd0, irq_en, ctrl_en};
            2'd1:    reg_rd = {21'd0, line_cmp};
            2'd2:    reg_rd = frame;
            default: reg_rd = {5'd0, v, 5'd0, h};
        endcase
    end

    // Flags are registered from the next counter values so they never skew against the counters.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            h             <= '0;
            v             <= '0;
            frame         <= '0;
            o_hblank      <= 1'b1;
            o_vblank      <= 1'b1;
            o_data_enable <= 1'b1;
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_line_irq    <= 1'b0;
        end else if (!en_next) begin
            h             <= '0;
            v             <= '0;
            o_hblank      <= 1'b0;
            o_vblank      <= 1'b0;
            o_data_enable <= 1'b0;
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_line_irq    <= 1'b0;
        end else if (i_pixel_enable || !ctrl_en) begin
            h             <= h_n;
            v             <= v_n;
            o_hblank      <= (h_n < H_VIS);
            o_vblank      <= (v_n < V_VIS);
            o_data_enable <= (h_n < H_VIS) && (v_n < V_VIS);
            o_hsync       <= ((h_n >= H_SS) && (h_n < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
            o_vsync       <= ((v_n >= V_SS) && (v_n < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
            o_line_irq    <= step && h_wrap && irq_en && (v_n == line_cmp);
            if (step && h_wrap && v_wrap) begin
                frame <= frame + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            ctrl_en     <= 1'b1;
            irq_en      <= 1'b0;
            line_cmp    <= '0;
            o_cpu_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cpu_request) begin
                        o_cpu_rdata <= reg_rd;
                        state       <= ST_ACK;
                    end
                    if (wr_ctrl) begin
                        ctrl_en <= i_cpu_wdata[0];
                        irq_en  <= i_cpu_wdata[1];
                    end
                    if (wr_cmp) begin
                        line_cmp <= i_cpu_wdata[10:0];
                    end
                end
                ST_ACK:  state <= i_cpu_request ? ST_HOLD : ST_IDLE;
                ST_HOLD: if (!i_cpu_request) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_cpu_ready = (state == ST_ACK) || ((state == ST_HOLD) && i_cpu_request);
    assign o_pos_x     = h;
    assign o_pos_y     = v;

    logic unused_bits;
    assign unused_bits = ^{i_cpu_address[31:4], i_cpu_address[1:0], i_cpu_wdata[31:11]};
endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing on a 14x7 raster (H 8/2/2/2, V 4/1/1/1, active-low syncs).
module tb_video_timing;
    logic        clk = 1'b0, rst = 1'b1, pe = 1'b1, req = 1'b0, rw = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready, hb, vb, hs, vs, de, irq;
    logic [10:0] px, py;

    int n_cmp = 0, n_bad = 0;
    int pos = 0, frames = 0, cnt = 0;
    logic run = 1'b1;

    always #5 clk = ~clk;

    video_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_pixel_enable(pe),
        .i_cpu_request(req), .i_cpu_rw(rw), .i_cpu_address(addr), .i_cpu_wdata(wdata),
        .o_cpu_rdata(rdata), .o_cpu_ready(ready),
        .o_hblank(hb), .o_vblank(vb), .o_hsync(hs), .o_vsync(vs), .o_data_enable(de),
        .o_pos_x(px), .o_pos_y(py), .o_line_irq(irq)
    );

    typedef struct {
        int   k;
        int   x;
        int   y;
        logic hb, vb, hs, vs;
    } vec_t;
    vec_t tbl[15];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void advance();
        if (pos == 97) begin
            pos = 0;
            frames++;
        end else begin
            pos++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (run && pe) advance();
    endtask

    task automatic check_video(string name);
        int h, v;
        logic ehb, evb, ehs, evs;
        h = pos % 14;
        v = pos / 14;
        if (run) begin
            ehb = (h < 8);
            evb = (v < 4);
            ehs = !(h == 10 || h == 11);
            evs = (v != 5);
        end else begin
            h = 0; v = 0;
            ehb = 1'b0; evb = 1'b0; ehs = 1'b1; evs = 1'b1;
        end
        check(name, 64'({px, py, hb, vb, hs, vs, de}),
              64'({11'(h), 11'(v), ehb, evb, ehs, evs, ehb & evb}));
    endtask

    task automatic advance_to(int target);
        for (int i = 0; i < 300 && pos != target; i++) tick();
        check_video("advance_to");
    endtask

    task automatic cpu_start(logic w, logic [31:0] a, logic [31:0] d);
        req = 1'b1; rw = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (w && a[3:2] == 2'd0) begin
            if (!d[0]) pos = 0;
            else if (run && pe) advance();
            run = d[0];
        end else if (run && pe) begin
            advance();
        end
        check("ready_ack", 64'(ready), 64'(1));
    endtask

    task automatic cpu_end();
        tick();
        check("ready_hold", 64'(ready), 64'(1));
        req = 1'b0;
        #1;
        check("ready_drop", 64'(ready), 64'(0));
        tick();
    endtask

    task automatic cpu_read(string name, logic [31:0] a, logic [31:0] exp);
        cpu_start(1'b0, a, '0);
        check(name, 64'(rdata), 64'(exp));
        cpu_end();
    endtask

    task automatic cpu_write(logic [31:0] a, logic [31:0] d);
        cpu_start(1'b1, a, d);
        cpu_end();
    endtask

    initial begin
        int pulses, h0, v0;

        //            k   x  y  hb vb hs vs
        tbl[0]  = '{  0,  0, 0, 1, 1, 1, 1};
        tbl[1]  = '{  7,  7, 0, 1, 1, 1, 1};
        tbl[2]  = '{  8,  8, 0, 0, 1, 1, 1};
        tbl[3]  = '{  9,  9, 0, 0, 1, 1, 1};
        tbl[4]  = '{ 10, 10, 0, 0, 1, 0, 1};
        tbl[5]  = '{ 11, 11, 0, 0, 1, 0, 1};
        tbl[6]  = '{ 12, 12, 0, 0, 1, 1, 1};
        tbl[7]  = '{ 14,  0, 1, 1, 1, 1, 1};
        tbl[8]  = '{ 56,  0, 4, 1, 0, 1, 1};
        tbl[9]  = '{ 70,  0, 5, 1, 0, 1, 0};
        tbl[10] = '{ 83, 13, 5, 0, 0, 1, 0};
        tbl[11] = '{ 84,  0, 6, 1, 0, 1, 1};
        tbl[12] = '{ 94, 10, 6, 0, 0, 0, 1};
        tbl[13] = '{ 97, 13, 6, 0, 0, 1, 1};
        tbl[14] = '{ 98,  0, 0, 1, 1, 1, 1};

        #12;
        check("rst_hold_video", 64'({px, py, hb, vb, hs, vs, de}), 64'({22'd0, 5'b11111}));
        check("rst_hold_cpu", 64'({ready, irq, rdata}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        pos = 0; frames = 0; run = 1'b1; cnt = 0;

        for (int i = 0; i < 15; i++) begin
            while (cnt < tbl[i].k) begin
                tick();
                cnt++;
                check("irq_quiet", 64'(irq), 64'(0));
            end
            check($sformatf("scan_k%0d", tbl[i].k), 64'({px, py, hb, vb, hs, vs, de}),
                  64'({11'(tbl[i].x), 11'(tbl[i].y), tbl[i].hb, tbl[i].vb, tbl[i].hs, tbl[i].vs,
                       tbl[i].hb & tbl[i].vb}));
        end

        cpu_read("frame_one", 32'h8, 32'd1);
        cpu_read("ctrl_rst", 32'h0, 32'd1);
        cpu_read("cmp_rst", 32'h4, 32'd0);
        advance_to(33);
        cpu_read("status", 32'hC, 32'h0002_0005);

        cpu_write(32'h8, 32'hDEAD_BEEF);
        cpu_read("frame_ro", 32'h8, 32'(frames));
        cpu_write(32'h0, 32'hFFFF_FFFF);
        cpu_read("ctrl_mask", 32'h0, 32'd3);
        cpu_write(32'h4, 32'hFFFF_F802);
        cpu_read("cmp_mask", 32'h4, 32'd2);

        pulses = 0;
        for (int i = 0; i < 196; i++) begin
            tick();
            check("irq_scan", 64'(irq), 64'(pos == 28));
            if (irq) pulses++;
        end
        check("irq_pulses", 64'(pulses), 64'(2));

        // LINE_CMP written on the very edge that reaches (0,2): old value still compares.
        advance_to(27);
        cpu_start(1'b1, 32'h4, 32'd3);
        check("cmp_old", 64'({irq, px, py}), 64'({1'b1, 11'd0, 11'd2}));
        cpu_end();
        advance_to(42);
        check("cmp_new", 64'(irq), 64'(1));
        advance_to(28);
        check("cmp_old_gone", 64'(irq), 64'(0));

        cpu_write(32'h4, 32'd7);
        pulses = 0;
        for (int i = 0; i < 98; i++) begin
            tick();
            if (irq) pulses++;
        end
        check("cmp_out_of_range", 64'(pulses), 64'(0));

        cpu_write(32'h4, 32'd2);
        advance_to(27);
        tick();
        check("freeze_irq_set", 64'(irq), 64'(1));
        pe = 1'b0;
        repeat (3) tick();
        check("freeze_irq_held", 64'(irq), 64'(1));
        check_video("freeze_pos");
        pe = 1'b1;
        tick();
        check("freeze_irq_clear", 64'(irq), 64'(0));
        check_video("freeze_resume");

        h0 = pos % 14;
        v0 = pos / 14;
        for (int i = 0; i < 28; i++) begin
            pe = (i % 2 == 0);
            tick();
            check_video("toggle");
        end
        pe = 1'b1;
        check("row_len", 64'({px, py}), 64'({11'(h0), 11'((v0 + 1) % 7)}));

        advance_to(47);
        cpu_start(1'b1, 32'h0, 32'd0);
        check("disable", 64'({px, py, hb, vb, de, irq}), 64'(0));
        check_video("disable_model");
        cpu_end();
        repeat (5) tick();
        check_video("disabled_hold");
        cpu_start(1'b1, 32'h0, 32'd1);
        check("restart", 64'({px, py, hb, vb, de}), 64'({22'd0, 3'b111}));
        cpu_end();
        check_video("resume");

        advance_to(86);
        cpu_start(1'b1, 32'h4, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_video", 64'({px, py, hb, vb, hs, vs, de}), 64'({22'd0, 5'b11111}));
        check("rst_mid_ready", 64'(ready), 64'(0));
        check("rst_mid_rdata", 64'(rdata), 64'(0));
        check("rst_mid_irq", 64'(irq), 64'(0));
        req = 1'b0;
        rw = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pos = 0; frames = 0; run = 1'b1;
        check_video("post_reset");
        cpu_read("post_cmp", 32'h4, 32'd0);
        cpu_read("post_ctrl", 32'h0, 32'd1);
        cpu_read("post_frame", 32'h8, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
